// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the PC / process-context sequencer
// Purpose: FSM state encoding, region geometry and default vectors.
// Ports: none (package).
package pc_sequencer_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam int         PROC_BITS_DEF   = 2;
    localparam int         OFFSET_BITS_DEF = 9;
    localparam int         ADDR_WIDTH_DEF  = 13;
    localparam int         NUM_PROCS       = 1 << PROC_BITS_DEF;
    localparam int         REGION_WORDS    = 1 << OFFSET_BITS_DEF;
    localparam logic [1:0] OS_PROC_ID      = 2'd0;
    localparam logic [8:0] TRAP_VECTOR_DEF = 9'd8;
    localparam logic [8:0] BOOT_OFFSET_DEF = 9'd0;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/fetch bundle between OS control logic and the sequencer
// Purpose: groups the fetch-control requests and the PC/status outputs.
// Ports: master drives Stall, Branch_En, Branch_Target, Trap, Switch_Req,
//        Switch_Proc, Halt, Resume; slave drives PC, Cur_Proc, Instr_Valid, Switch_Ack.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int PROC_BITS   = PROC_BITS_DEF,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
);
    logic                   Stall;
    logic                   Branch_En;
    logic [OFFSET_BITS-1:0] Branch_Target;
    logic                   Trap;
    logic                   Switch_Req;
    logic [PROC_BITS-1:0]   Switch_Proc;
    logic                   Halt;
    logic                   Resume;
    logic [ADDR_WIDTH-1:0]  PC;
    logic [PROC_BITS-1:0]   Cur_Proc;
    logic                   Instr_Valid;
    logic                   Switch_Ack;

    modport master (
        output Stall, Branch_En, Branch_Target, Trap, Switch_Req, Switch_Proc, Halt, Resume,
        input  PC, Cur_Proc, Instr_Valid, Switch_Ack
    );

    modport slave (
        input  Stall, Branch_En, Branch_Target, Trap, Switch_Req, Switch_Proc, Halt, Resume,
        output PC, Cur_Proc, Instr_Valid, Switch_Ack
    );
endinterface

// File: rtl/pc_sequencer_ctx_save_table.sv
// rtl/pc_sequencer_ctx_save_table.sv - per-process saved resume offsets
// Purpose: NUM_PROCS x OFFSET_BITS register file, async reset to 0.
// Ports: clk, rst; wr_en/wr_idx/wr_data write port; rd_idx -> rd_data combinational
//        read of the registered contents (same-edge write is not forwarded).
module ctx_save_table
    import pc_sequencer_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_PROCS,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF,
    parameter int IDX_BITS    = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IDX_BITS-1:0]    wr_idx,
    input  logic [OFFSET_BITS-1:0] wr_data,
    input  logic [IDX_BITS-1:0]    rd_idx,
    output logic [OFFSET_BITS-1:0] rd_data
);
    logic [OFFSET_BITS-1:0] save_q [NUM_ENTRIES];
    logic [OFFSET_BITS-1:0] save_d [NUM_ENTRIES];

    always_comb begin
        save_d = save_q;
        if (wr_en) begin
            save_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                save_q[i] <= '0;
            end
        end else begin
            save_q <= save_d;
        end
    end

    assign rd_data = save_q[rd_idx];
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and process-context unit for the instruction ROM
// Purpose: RUN/HALTED FSM, trap/switch/branch priority mux, offset register,
//          registered Instr_Valid and Switch_Ack.
// Ports: Fast_Clock, Reset (async, active-high); bus (pc_sequencer_if.slave).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                   ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int                   PROC_BITS   = PROC_BITS_DEF,
    parameter int                   OFFSET_BITS = OFFSET_BITS_DEF,
    parameter logic [OFFSET_BITS-1:0] TRAP_VECTOR = TRAP_VECTOR_DEF,
    parameter logic [OFFSET_BITS-1:0] BOOT_OFFSET = BOOT_OFFSET_DEF
) (
    input  logic Fast_Clock,
    input  logic Reset,
    pc_sequencer_if.slave bus
);
    localparam logic [PROC_BITS-1:0] OS_ID = PROC_BITS'(OS_PROC_ID);

    state_t                 state_q, state_d;
    logic [PROC_BITS-1:0]   proc_q, proc_d;
    logic [OFFSET_BITS-1:0] offset_q, offset_d;
    logic                   valid_q, valid_d;
    logic                   ack_q, ack_d;

    logic                   wr_en;
    logic [PROC_BITS-1:0]   wr_idx;
    logic [OFFSET_BITS-1:0] offset_inc;
    logic [OFFSET_BITS-1:0] saved_offset;
    logic                   trap_take;
    logic                   switch_take;
    logic                   redirect;

    // Wraps modulo the region size, so a region never spills into the next.
    assign offset_inc = offset_q + OFFSET_BITS'(1);

    // Each request is only legal from one side of the OS/user boundary; an
    // illegal one simply falls through to the lower-priority rules.
    assign trap_take   = bus.Trap && (proc_q != OS_ID);
    assign switch_take = bus.Switch_Req && (proc_q == OS_ID) && (bus.Switch_Proc != OS_ID);
    assign redirect    = trap_take || switch_take || bus.Branch_En;

    ctx_save_table #(
        .NUM_ENTRIES (1 << PROC_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .IDX_BITS    (PROC_BITS)
    ) u_ctx (
        .clk     (Fast_Clock),
        .rst     (Reset),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (offset_inc),
        .rd_idx  (bus.Switch_Proc),
        .rd_data (saved_offset)
    );

    always_comb begin
        state_d  = state_q;
        proc_d   = proc_q;
        offset_d = offset_q;
        valid_d  = 1'b0;
        ack_d    = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = proc_q;

        if (state_q == ST_HALTED) begin
            if (bus.Resume) begin
                state_d = ST_RUN;
            end
        end else begin
            if (trap_take) begin
                wr_en    = 1'b1;
                proc_d   = OS_ID;
                offset_d = TRAP_VECTOR;
                ack_d    = 1'b1;
            end else if (switch_take) begin
                // wr_idx is proc_q, which is the OS here.
                wr_en    = 1'b1;
                proc_d   = bus.Switch_Proc;
                offset_d = saved_offset;
                ack_d    = 1'b1;
            end else if (bus.Branch_En) begin
                offset_d = bus.Branch_Target;
            end else if (bus.Halt) begin
                state_d = ST_HALTED;
            end else if (!bus.Stall) begin
                offset_d = offset_inc;
            end
            // The ROM registers its address, so the word fetched on a redirect,
            // stall or halt edge is off-path and is flagged invalid next cycle.
            valid_d = !bus.Stall && !bus.Halt && !redirect;
        end
    end

    always_ff @(posedge Fast_Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_RUN;
            proc_q   <= OS_ID;
            offset_q <= BOOT_OFFSET;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            proc_q   <= proc_d;
            offset_q <= offset_d;
            valid_q  <= valid_d;
            ack_q    <= ack_d;
        end
    end

    assign bus.PC          = ADDR_WIDTH'({proc_q, offset_q});
    assign bus.Cur_Proc    = proc_q;
    assign bus.Instr_Valid = valid_q;
    assign bus.Switch_Ack  = ack_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .Fast_Clock (clk),
        .Reset      (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.Stall = 0; bus.Branch_En = 0; bus.Branch_Target = '0; bus.Trap = 0;
        bus.Switch_Req = 0; bus.Switch_Proc = '0; bus.Halt = 0; bus.Resume = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pc", bus.PC, 13'h000);
        chk("rst_proc", bus.Cur_Proc, 0);
        chk("rst_valid", bus.Instr_Valid, 0);
        chk("rst_ack", bus.Switch_Ack, 0);
        rst = 1'b0;

        // 1: free run
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("run_pc%0d", i), bus.PC, i);
            chk($sformatf("run_valid%0d", i), bus.Instr_Valid, (i != 0));
            tick();
        end

        // 2: OS at offset 20 dispatches proc 2
        bus.Branch_En = 1; bus.Branch_Target = 9'd20; tick(); idle();
        chk("br20_pc", bus.PC, 13'h014);
        chk("br20_valid", bus.Instr_Valid, 0);
        bus.Switch_Req = 1; bus.Switch_Proc = 2; tick(); idle();
        chk("sw2_pc", bus.PC, 13'h400);
        chk("sw2_proc", bus.Cur_Proc, 2);
        chk("sw2_ack", bus.Switch_Ack, 1);
        chk("sw2_valid", bus.Instr_Valid, 0);
        chk("save0", dut.u_ctx.save_q[0], 21);
        tick();
        chk("sw2_next_pc", bus.PC, 13'h401);
        chk("sw2_ack_drop", bus.Switch_Ack, 0);
        chk("sw2_valid_back", bus.Instr_Valid, 1);

        // 3: proc 2 at 37 traps, then is resumed
        bus.Branch_En = 1; bus.Branch_Target = 9'd37; tick(); idle();
        chk("br37_pc", bus.PC, 13'h425);
        bus.Trap = 1; tick(); idle();
        chk("trap_pc", bus.PC, 13'h008);
        chk("trap_proc", bus.Cur_Proc, 0);
        chk("trap_ack", bus.Switch_Ack, 1);
        chk("save2", dut.u_ctx.save_q[2], 38);
        bus.Trap = 1; tick(); idle();
        chk("os_trap_ignored_pc", bus.PC, 13'h009);
        chk("os_trap_ignored_ack", bus.Switch_Ack, 0);
        chk("os_trap_ignored_valid", bus.Instr_Valid, 1);
        bus.Switch_Req = 1; bus.Switch_Proc = 0; tick(); idle();
        chk("sw0_ignored_pc", bus.PC, 13'h00A);
        bus.Switch_Req = 1; bus.Switch_Proc = 2; tick(); idle();
        chk("resume2_pc", bus.PC, 13'h426);
        chk("resume2_ack", bus.Switch_Ack, 1);
        bus.Switch_Req = 1; bus.Switch_Proc = 3; tick(); idle();
        chk("user_sw_ignored_pc", bus.PC, 13'h427);
        chk("user_sw_ignored_ack", bus.Switch_Ack, 0);
        bus.Trap = 1; bus.Switch_Req = 1; bus.Switch_Proc = 3; tick(); idle();
        chk("trap_sw_pc", bus.PC, 13'h008);
        chk("save2_b", dut.u_ctx.save_q[2], 40);
        bus.Switch_Req = 1; bus.Switch_Proc = 3; tick(); idle();
        chk("sw3_pc", bus.PC, 13'h600);

        // 4: wrap stays in region
        bus.Branch_En = 1; bus.Branch_Target = 9'd511; tick(); idle();
        chk("br511_pc", bus.PC, 13'h7FF);
        tick();
        chk("wrap_pc", bus.PC, 13'h600);
        chk("wrap_proc", bus.Cur_Proc, 3);
        chk("wrap_valid", bus.Instr_Valid, 1);

        // 5: 3-cycle stall with branch in the 2nd stall cycle
        bus.Stall = 1; tick();
        chk("stall1_pc", bus.PC, 13'h600);
        chk("stall1_valid", bus.Instr_Valid, 0);
        bus.Branch_En = 1; bus.Branch_Target = 9'd100; tick(); bus.Branch_En = 0;
        chk("stall2_pc", bus.PC, 13'h664);
        chk("stall2_valid", bus.Instr_Valid, 0);
        tick(); idle();
        chk("stall3_pc", bus.PC, 13'h664);
        chk("stall3_valid", bus.Instr_Valid, 0);
        tick();
        chk("post_stall_pc", bus.PC, 13'h665);
        chk("post_stall_valid", bus.Instr_Valid, 1);

        // 6: halt, trap while halted, resume, async reset mid-cycle
        bus.Halt = 1; tick(); idle();
        chk("halt_pc", bus.PC, 13'h665);
        chk("halt_valid", bus.Instr_Valid, 0);
        bus.Trap = 1; tick(); idle();
        chk("halt_trap_pc", bus.PC, 13'h665);
        chk("halt_trap_proc", bus.Cur_Proc, 3);
        chk("halt_trap_ack", bus.Switch_Ack, 0);
        tick();
        chk("halt_hold_pc", bus.PC, 13'h665);
        bus.Resume = 1; tick(); idle();
        chk("resume_pc", bus.PC, 13'h665);
        chk("resume_valid", bus.Instr_Valid, 0);
        tick();
        chk("run_again_pc", bus.PC, 13'h666);
        chk("run_again_valid", bus.Instr_Valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pc", bus.PC, 13'h000);
        chk("async_rst_proc", bus.Cur_Proc, 0);
        chk("async_rst_valid", bus.Instr_Valid, 0);
        chk("async_rst_save2", dut.u_ctx.save_q[2], 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("after_rst_pc", bus.PC, 13'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
